// File: rtl/ama_riscv_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, UNROLL bits per cycle.
// Define AMA_RISCV_MULDIV_EARLY_OUT_EN to let multiplies finish once remaining multiplier bits are 0.
module ama_riscv_muldiv_seq #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  input  logic            flush,
  output logic            busy
);

  localparam int unsigned ITER = XLEN / UNROLL;
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [CntW-1:0]   cnt_q;
  // Multiply: acc_q is the running product, mcand_q the shifted multiplicand, mplier_q the
  // multiplier. Divide: acc_q[XLEN-1:0] is the remainder, mcand_q[XLEN-1:0] the divisor and
  // mplier_q shifts the dividend out while the quotient shifts in.
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   rsp_data_q;

  logic              a_neg, b_neg, req_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    a_neg       = (req_op inside {OpMulh, OpMulhsu, OpDiv, OpRem}) && req_a[XLEN-1];
    b_neg       = (req_op inside {OpMulh, OpDiv, OpRem}) && req_b[XLEN-1];
    a_mag       = a_neg ? -req_a : req_a;
    b_mag       = b_neg ? -req_b : req_b;
    // Remainder sign follows the dividend; everything else follows the sign product.
    req_neg     = (req_op == OpRem) ? a_neg : (a_neg ^ b_neg);
    div_by_zero = req_op[2] && (req_b == '0);
    div_ovf     = (req_op inside {OpDiv, OpRem}) && (req_a == MinVal) && (req_b == '1);
    special     = div_by_zero || div_ovf;
    if (div_by_zero) special_res = req_op[1] ? req_a : '1;
    else             special_res = req_op[1] ? '0 : req_a;
  end

  logic [2*XLEN-1:0] mul_acc, mul_mcand;
  logic [XLEN-1:0]   mul_mplier;
  logic [XLEN-1:0]   div_rem, div_quo, divisor;
  logic [XLEN:0]     div_trial;

  always_comb begin
    mul_acc    = acc_q;
    mul_mcand  = mcand_q;
    mul_mplier = mplier_q;
    div_rem    = acc_q[XLEN-1:0];
    div_quo    = mplier_q;
    divisor    = mcand_q[XLEN-1:0];
    div_trial  = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (mul_mplier[0]) mul_acc = mul_acc + mul_mcand;
      mul_mcand  = mul_mcand << 1;
      mul_mplier = mul_mplier >> 1;

      div_trial = {div_rem, div_quo[XLEN-1]};
      div_quo   = div_quo << 1;
      if (div_trial >= {1'b0, divisor}) begin
        div_rem    = div_trial[XLEN-1:0] - divisor;
        div_quo[0] = 1'b1;
      end else begin
        div_rem = div_trial[XLEN-1:0];
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   calc_res;

  always_comb begin
    prod = neg_q ? -mul_acc : mul_acc;
    unique case (op_q)
      OpMul:                      calc_res = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  calc_res = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              calc_res = neg_q ? -div_quo : div_quo;
      OpRem, OpRemu:              calc_res = neg_q ? -div_rem : div_rem;
      default:                    calc_res = '0;
    endcase
  end

  logic calc_last;
`ifdef AMA_RISCV_MULDIV_EARLY_OUT_EN
  assign calc_last = (cnt_q == '0) || (!op_q[2] && (mul_mplier == '0));
`else
  assign calc_last = (cnt_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rsp_data_q <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q  <= req_op;
            neg_q <= req_neg;
            if (special) begin
              rsp_data_q <= special_res;
              state_q    <= StDone;
            end else begin
              cnt_q   <= CntW'(ITER - 1);
              acc_q   <= '0;
              state_q <= StCalc;
              if (req_op[2]) begin
                mcand_q  <= {{XLEN{1'b0}}, b_mag};
                mplier_q <= a_mag;
              end else begin
                mcand_q  <= {{XLEN{1'b0}}, a_mag};
                mplier_q <= b_mag;
              end
            end
          end
        end
        StCalc: begin
          cnt_q <= cnt_q - 1'b1;
          if (op_q[2]) begin
            acc_q    <= {{XLEN{1'b0}}, div_rem};
            mplier_q <= div_quo;
          end else begin
            acc_q    <= mul_acc;
            mcand_q  <= mul_mcand;
            mplier_q <= mul_mplier;
          end
          if (calc_last) begin
            rsp_data_q <= calc_res;
            state_q    <= StDone;
          end
        end
        StDone: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle) && !flush && !rst;
  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ama_riscv_muldiv_seq.sv
// Directed bench for ama_riscv_muldiv_seq: results, latency, special cases, flush/reset, back-pressure.
module tb_ama_riscv_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid, rsp_ready, flush, busy;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, rsp_data;

  logic        r4_valid, r4_ready, r4_rsp_valid, r4_rsp_ready, r4_busy;
  logic [2:0]  r4_op;
  logic [31:0] r4_a, r4_b, r4_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ama_riscv_muldiv_seq #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .flush(flush), .busy(busy)
  );

  ama_riscv_muldiv_seq #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(r4_valid), .req_ready(r4_ready), .req_op(r4_op),
    .req_a(r4_a), .req_b(r4_b), .rsp_valid(r4_rsp_valid), .rsp_ready(r4_rsp_ready),
    .rsp_data(r4_data), .flush(1'b0), .busy(r4_busy)
  );

`ifdef AMA_RISCV_MULDIV_EARLY_OUT_EN
  localparam int EoLatB3 = 3;
  localparam int EoLatB0 = 2;
`else
  localparam int EoLatB3 = 33;
  localparam int EoLatB0 = 33;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one request, wait (bounded) for the response; lat = 0 means it never came.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit pop, output logic [31:0] data, output int lat);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat  = 0;
    data = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat  = n;
        data = rsp_data;
        break;
      end
    end
    if (pop && lat != 0) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] d;
    int          lat;
    run_op(op, a, b, 1'b1, d, lat);
    check({tag, "_data"}, d, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] d;
    int          lat, seen;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    r4_valid = 1'b0; r4_rsp_ready = 1'b0; r4_op = '0; r4_a = '0; r4_b = '0;
    repeat (2) @(negedge clk);
    check("ready_in_rst", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_data", rsp_data, 32'd0);

    op_check("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    op_check("mulhu", 3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
    op_check("mulh_neg", 3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    op_check("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    op_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    op_check("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    op_check("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    op_check("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    op_check("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);

    op_check("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    op_check("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    op_check("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op_check("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Back-pressure: response must hold while rsp_ready stays low.
    run_op(3'd5, 32'd100, 32'd7, 1'b0, d, lat);
    check("bp_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data", rsp_data, 32'd14);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_idle", {31'b0, busy}, 32'd0);

    // Flush in CALC cycle 5: back to idle with no response.
    @(negedge clk);
    req_op = 3'd0; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("fl_busy_calc", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("fl_busy", {31'b0, busy}, 32'd0);
    check("fl_valid", {31'b0, rsp_valid}, 32'd0);
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("fl_no_rsp", 32'(seen), 32'd0);

    // Flush and request together: flush wins.
    @(negedge clk);
    req_op = 3'd5; req_a = 32'd9; req_b = 32'd3; req_valid = 1'b1; flush = 1'b1;
    #1;
    check("fl_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("fl_req_busy", {31'b0, busy}, 32'd0);

    // Reset mid-CALC.
    run_op(3'd7, 32'd100, 32'd7, 1'b1, d, lat);
    check("pre_rst_data", d, 32'd2);
    @(negedge clk);
    req_op = 3'd4; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_valid", {31'b0, rsp_valid}, 32'd0);
    check("mr_data", rsp_data, 32'd0);
    rst = 1'b0;
    #1;
    check("mr_ready", {31'b0, req_ready}, 32'd1);

    op_check("mul_b3", 3'd0, 32'd12345, 32'd3, 32'd37035, EoLatB3);
    op_check("mul_b0", 3'd0, 32'd12345, 32'd0, 32'd0, EoLatB0);

    // UNROLL=4 instance.
    @(negedge clk);
    r4_op = 3'd5; r4_a = 32'hFFFF_FFFF; r4_b = 32'h10; r4_valid = 1'b1;
    @(posedge clk);
    #1 r4_valid = 1'b0;
    lat = 0;
    d   = '0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (r4_rsp_valid) begin
        lat = n;
        d   = r4_data;
        break;
      end
    end
    check("u4_data", d, 32'h0FFF_FFFF);
    check("u4_lat", 32'(lat), 32'd9);
    r4_rsp_ready = 1'b1;
    @(posedge clk);
    #1 r4_rsp_ready = 1'b0;
    @(negedge clk);
    check("u4_idle", {31'b0, r4_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ama_riscv_muldiv_seq.md
Name: ama_riscv_muldiv_seq

Overview:
Iterative multiply/divide unit for the RV32M extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), generalised in operand width and bits retired per cycle. It sits beside the single-cycle ALU in the execute stage. It accepts one operation through a valid/ready request port and returns the result through a valid/ready response port. The pipeline stalls on req_ready/rsp_valid and can abort an in-flight operation with flush.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2 and ≥ 8.
- UNROLL, 1, quotient/multiplier bits processed per cycle; must divide XLEN; legal values 1, 2, 4.
- ITER (localparam), XLEN/UNROLL, number of CALC cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; equals (state==IDLE) && !flush && !rst
- req_op  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_a  in  XLEN  rs1 operand (dividend / multiplicand)
- req_b  in  XLEN  rs2 operand (divisor / multiplier)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  XLEN  result
- flush  in  1  abort current operation
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, busy 0. req_ready is 0 while rst is high and 1 on the first cycle after.
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC on handshake (req_valid && req_ready). Operands, op and a signed-result flag are captured. Signed operands are converted to magnitudes: req_a for MULH/MULHSU/DIV/REM; req_b for MULH/DIV/REM.
  - IDLE→DONE directly for the special cases below.
  - CALC runs exactly ITER cycles. Each cycle processes UNROLL bits: shift-add for multiply, restoring subtract for divide. An iteration counter counts ITER-1 down to 0.
  - CALC→DONE when the counter reaches 0. The final sign correction and result select are registered into rsp_data on that transition.
  - DONE: rsp_valid=1, rsp_data stable. DONE→IDLE on rsp_ready. There is no back-to-back accept in the DONE-exit cycle, because req_ready is only high in IDLE.
- Latency: handshake at cycle 0 → rsp_valid first high at cycle ITER+1 (33 for the defaults).
- Results:
  - MUL: low XLEN bits of the 2·XLEN product.
  - MULH/MULHSU/MULHU: high XLEN bits. Sign correction is a two's-complement negate of the full 2·XLEN magnitude product when the operand signs differ.
  - DIV/DIVU: quotient truncated toward zero.
  - REM/REMU: remainder; its sign follows the dividend.
- Special cases (rsp_valid at cycle 1, no CALC):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → req_a.
  - Signed overflow, DIV with a = 1<<(XLEN-1) and b = −1: result a. REM with the same operands: result 0.
- flush: in any state, the state goes to IDLE at the next edge, rsp_valid drops at that edge, and the partial result is discarded. If flush and req_valid are high in the same cycle, flush wins and the request is not accepted. If flush and rsp_ready are high together in DONE, the unit goes to IDLE and the response counts as consumed.
- Reset mid-operation: identical to flush, plus all outputs return to their reset values.
- Back-pressure: rsp_data and rsp_valid hold indefinitely while rsp_ready=0.

Optional Feature:
- Macro: AMA_RISCV_MULDIV_EARLY_OUT_EN.
- Defined: for MUL/MULH/MULHSU/MULHU, CALC exits as soon as the unprocessed multiplier bits are all zero, after a minimum of 1 CALC cycle. Latency becomes k+1 cycles, where k = max(1, ceil((msb_index(|b|)+1)/UNROLL)); b=0 gives k=1. Divide latency is unchanged.
- Undefined: every non-special operation takes exactly ITER CALC cycles (fixed latency).

Test Plan:
- MUL a=7, b=−3 (0xFFFFFFFD), XLEN=32, UNROLL=1 → rsp_valid at cycle 33, rsp_data 0xFFFFFFEB. MULHU with the same operands → 0x00000006.
- DIV a=−7, b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU → 2.
- Special cases, each with rsp_valid at cycle 1:
  - DIVU a=5, b=0 → 0xFFFFFFFF; REM a=5, b=0 → 5.
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Handshakes:
  - Hold rsp_ready=0 for 10 cycles in DONE → rsp_data stable, req_ready=0 throughout.
  - Assert flush at CALC cycle 5 → IDLE next cycle, no rsp_valid.
  - Assert rst mid-CALC → outputs at reset values.
- UNROLL=4 build: DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF, rsp_valid at cycle 9.
- With AMA_RISCV_MULDIV_EARLY_OUT_EN, UNROLL=1: MUL 12345 × 3 → 37035 with rsp_valid at cycle 3. MUL × 0 → 0 at cycle 2. Without the macro, both respond at cycle 33.
